// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache port scheduler.
package cache_pkg;

    typedef enum logic [1:0] {
        SCH_IDLE      = 2'd0,
        SCH_ISSUE     = 2'd1,
        SCH_WAIT_RESP = 2'd2
    } sch_state_t;

    localparam int unsigned MaxClients = 32;

    // Index of the set bit in a one-hot vector; zero input yields 0.
    function automatic logic [7:0] onehot2idx(input logic [MaxClients-1:0] oh);
        logic [7:0] idx;
        idx = '0;
        for (int i = 0; i < MaxClients; i++) begin
            if (oh[i]) idx = idx | 8'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_port_scheduler_if.sv
// Client-side and cache-side handshake bundle of the cache port scheduler.
interface cache_port_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]        cli_req_valid;
    logic [NUM_REQ-1:0]        cli_req_ready;
    logic [NUM_REQ-1:0]        cli_req_wr;
    logic [NUM_REQ*ADDR_W-1:0] cli_req_addr;
    logic [NUM_REQ*DATA_W-1:0] cli_req_wdata;
    logic [NUM_REQ-1:0]        cli_resp_valid;
    logic [DATA_W-1:0]         cli_resp_rdata;
    logic                      cache_req_valid;
    logic                      cache_req_ready;
    logic                      cache_req_wr;
    logic [ADDR_W-1:0]         cache_req_addr;
    logic [DATA_W-1:0]         cache_req_wdata;
    logic                      cache_resp_valid;
    logic [DATA_W-1:0]         cache_resp_rdata;

    // Scheduler view.
    modport slave (
        input  cli_req_valid, cli_req_wr, cli_req_addr, cli_req_wdata,
        input  cache_req_ready, cache_resp_valid, cache_resp_rdata,
        output cli_req_ready, cli_resp_valid, cli_resp_rdata,
        output cache_req_valid, cache_req_wr, cache_req_addr, cache_req_wdata
    );

    // Environment view: clients plus cache front end.
    modport master (
        output cli_req_valid, cli_req_wr, cli_req_addr, cli_req_wdata,
        output cache_req_ready, cache_resp_valid, cache_resp_rdata,
        input  cli_req_ready, cli_resp_valid, cli_resp_rdata,
        input  cache_req_valid, cache_req_wr, cache_req_addr, cache_req_wdata
    );
endinterface

// File: rtl/cache_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping upward.
module cache_rr_pick
    import cache_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_onehot_o,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            any_o
);
    localparam logic [N-1:0]    One  = 1;
    localparam logic [IdxW:0]   NumW = (IdxW + 1)'(N);

    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [N-1:0]    first;
    logic [IdxW-1:0] off;
    logic [IdxW:0]   sum;

    // Rotate so ptr_i lands on bit 0, then isolate the lowest set bit.
    assign dbl   = {req_i, req_i} >> ptr_i;
    assign rot   = dbl[N-1:0];
    assign first = rot & (~rot + One);
    assign off   = IdxW'(onehot2idx(MaxClients'(first)));
    assign sum   = {1'b0, ptr_i} + {1'b0, off};

    assign gnt_idx_o    = (sum >= NumW) ? IdxW'(sum - NumW) : sum[IdxW-1:0];
    assign any_o        = |req_i;
    assign gnt_onehot_o = any_o ? (One << gnt_idx_o) : '0;
endmodule

// File: rtl/cache_port_scheduler.sv
// Shares one cache port among NUM_REQ clients, one transaction in flight, round-robin.
module cache_port_scheduler
    import cache_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_port_scheduler_if.slave bus,
    output logic                 busy,
    output logic [IdxW-1:0]      owner,
    output logic                 err_stray_resp
);
    localparam logic [NUM_REQ-1:0] OneHot0 = 1;

    sch_state_t          state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                stray_q, stray_d;

    logic [NUM_REQ-1:0]  gnt_onehot;
    logic [IdxW-1:0]     gnt_idx;
    logic                gnt_any;

    cache_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i        (bus.cli_req_valid),
        .ptr_i        (ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .any_o        (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stray_d = stray_q | (bus.cache_resp_valid & (state_q != SCH_WAIT_RESP));

        bus.cli_req_ready   = '0;
        bus.cache_req_valid = 1'b0;
        bus.cli_resp_valid  = '0;
        bus.cli_resp_rdata  = '0;

        unique case (state_q)
            SCH_IDLE: begin
                // The picker only grants a valid client, so a grant is a transfer.
                bus.cli_req_ready = gnt_onehot;
                if (gnt_any) begin
                    owner_d = gnt_idx;
                    wr_d    = bus.cli_req_wr[gnt_idx];
                    addr_d  = bus.cli_req_addr[gnt_idx*ADDR_W +: ADDR_W];
                    wdata_d = bus.cli_req_wdata[gnt_idx*DATA_W +: DATA_W];
                    state_d = SCH_ISSUE;
                end
            end
            SCH_ISSUE: begin
                bus.cache_req_valid = 1'b1;
                if (bus.cache_req_ready) state_d = SCH_WAIT_RESP;
            end
            SCH_WAIT_RESP: begin
                if (bus.cache_resp_valid) begin
                    bus.cli_resp_valid = OneHot0 << owner_q;
                    bus.cli_resp_rdata = bus.cache_resp_rdata;
                    ptr_d   = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);
                    state_d = SCH_IDLE;
                end
            end
            default: state_d = SCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCH_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            stray_q <= stray_d;
        end
    end

    assign bus.cache_req_wr    = wr_q;
    assign bus.cache_req_addr  = addr_q;
    assign bus.cache_req_wdata = wdata_q;
    assign busy                = (state_q != SCH_IDLE);
    assign owner               = owner_q;
    assign err_stray_resp      = stray_q;
endmodule

// File: tb/tb_cache_port_scheduler.sv
// Directed bench for cache_port_scheduler with a transaction-level reference model.
module tb_cache_port_scheduler;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] owner;
    logic       err;

    always #5 clk = ~clk;

    cache_port_scheduler_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_port_scheduler #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy           (busy),
        .owner          (owner),
        .err_stray_resp (err)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;
    int grant_q[$];

    // Reference model: one outstanding transaction, issued or not yet issued.
    bit          m_busy, m_sent, m_stray, m_wr;
    int          m_owner, m_ptr;
    logic [31:0] m_addr, m_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_grant(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (p + i) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int         g;
        bit         resp_now;
        logic [3:0] exp_rdy;
        logic [3:0] exp_resp;
        if (chk_en) begin
            g        = m_busy ? -1 : pick_grant(bus.cli_req_valid, m_ptr);
            exp_rdy  = (g >= 0) ? (4'd1 << g) : 4'd0;
            resp_now = m_busy && m_sent && bus.cache_resp_valid;
            exp_resp = resp_now ? (4'd1 << m_owner) : 4'd0;
            chk("cli_req_ready", 64'(bus.cli_req_ready), 64'(exp_rdy));
            chk("cache_req_valid", 64'(bus.cache_req_valid), 64'(m_busy && !m_sent));
            if (m_busy && !m_sent) begin
                chk("cache_req_wr", 64'(bus.cache_req_wr), 64'(m_wr));
                chk("cache_req_addr", 64'(bus.cache_req_addr), 64'(m_addr));
                chk("cache_req_wdata", 64'(bus.cache_req_wdata), 64'(m_wdata));
            end
            chk("cli_resp_valid", 64'(bus.cli_resp_valid), 64'(exp_resp));
            if (resp_now) chk("cli_resp_rdata", 64'(bus.cli_resp_rdata), 64'(bus.cache_resp_rdata));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("owner", 64'(owner), 64'(m_owner));
            chk("err_stray_resp", 64'(err), 64'(m_stray));

            if (rst) begin
                m_busy = 0; m_sent = 0; m_stray = 0; m_wr = 0;
                m_owner = 0; m_ptr = 0; m_addr = '0; m_wdata = '0;
            end else begin
                if (bus.cache_resp_valid && !(m_busy && m_sent)) m_stray = 1;
                if (g >= 0) begin
                    grant_q.push_back(g);
                    m_busy  = 1;
                    m_sent  = 0;
                    m_owner = g;
                    m_wr    = bus.cli_req_wr[g];
                    m_addr  = bus.cli_req_addr[g*AW +: AW];
                    m_wdata = bus.cli_req_wdata[g*DW +: DW];
                end else if (m_busy && !m_sent && bus.cache_req_ready) begin
                    m_sent = 1;
                end else if (resp_now) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;
    endtask

    // Called in an accept cycle with cache_req_ready high; finishes that transaction.
    task automatic complete(input logic [31:0] rd);
        tick();
        bus.cli_req_valid = '0;
        tick();
        bus.cache_resp_valid = 1'b1;
        bus.cache_resp_rdata = rd;
        tick();
        bus.cache_resp_valid = 1'b0;
        bus.cache_resp_rdata = '0;
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    endtask

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        summary();
        $finish;
    end

    initial begin
        int exp2[5];
        exp2 = '{0, 1, 2, 3, 0};
        bus.cli_req_valid    = '0;
        bus.cli_req_wr       = '0;
        bus.cli_req_addr     = '0;
        bus.cli_req_wdata    = '0;
        bus.cache_req_ready  = 1'b0;
        bus.cache_resp_valid = 1'b0;
        bus.cache_resp_rdata = '0;

        // Reset values, then client 2 reads 0x100.
        do_reset();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cache_req_valid", 64'(bus.cache_req_valid), 64'd0);
        tick();
        bus.cli_req_valid        = 4'b0100;
        bus.cli_req_addr[64 +: 32] = 32'h100;
        bus.cache_req_ready      = 1'b1;
        @(negedge clk);
        chk("t1_ready", 64'(bus.cli_req_ready), 64'h4);
        tick();
        bus.cli_req_valid = '0;
        @(negedge clk);
        chk("t1_cache_valid", 64'(bus.cache_req_valid), 64'd1);
        chk("t1_addr", 64'(bus.cache_req_addr), 64'h100);
        chk("t1_wr", 64'(bus.cache_req_wr), 64'd0);
        tick();
        bus.cache_resp_valid = 1'b1;
        bus.cache_resp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_resp_valid", 64'(bus.cli_resp_valid), 64'h4);
        chk("t1_rdata", 64'(bus.cli_resp_rdata), 64'hDEADBEEF);
        tick();
        bus.cache_resp_valid = 1'b0;
        bus.cli_req_valid    = 4'b1111;
        @(negedge clk);
        chk("t1_ptr3_grant", 64'(bus.cli_req_ready), 64'h8);
        complete(32'h0);

        // All clients valid, immediate cache.
        do_reset();
        grant_q.delete();
        bus.cli_req_valid   = 4'b1111;
        bus.cache_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            tick();
            bus.cache_resp_valid = 1'b1;
            bus.cache_resp_rdata = 32'(k);
            tick();
            bus.cache_resp_valid = 1'b0;
        end
        bus.cli_req_valid = '0;
        @(negedge clk);
        chk("t2_count", 64'(grant_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < grant_q.size(); i++) chk("t2_order", 64'(grant_q[i]), 64'(exp2[i]));

        // Client 3 wins, then 0 and 3 contend: 0 wins after wrap.
        do_reset();
        bus.cli_req_valid = 4'b1000;
        @(negedge clk);
        chk("t3_first", 64'(bus.cli_req_ready), 64'h8);
        complete(32'h0);
        bus.cli_req_valid = 4'b1001;
        @(negedge clk);
        chk("t3_wrap", 64'(bus.cli_req_ready), 64'h1);
        complete(32'h0);

        // Cache stalls five cycles in ISSUE.
        do_reset();
        bus.cache_req_ready       = 1'b0;
        bus.cli_req_valid         = 4'b0010;
        bus.cli_req_wr            = 4'b0010;
        bus.cli_req_addr[32 +: 32]  = 32'h2000;
        bus.cli_req_wdata[32 +: 32] = 32'h55AA;
        @(negedge clk);
        tick();
        bus.cli_req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_valid", 64'(bus.cache_req_valid), 64'd1);
            chk("t4_addr", 64'(bus.cache_req_addr), 64'h2000);
            chk("t4_wdata", 64'(bus.cache_req_wdata), 64'h55AA);
            chk("t4_wr", 64'(bus.cache_req_wr), 64'd1);
            chk("t4_ready", 64'(bus.cli_req_ready), 64'd0);
            tick();
        end
        bus.cache_req_ready = 1'b1;
        tick();
        bus.cli_req_valid    = '0;
        bus.cli_req_wr       = '0;
        bus.cache_resp_valid = 1'b1;
        @(negedge clk);
        chk("t4_resp", 64'(bus.cli_resp_valid), 64'h2);
        tick();
        bus.cache_resp_valid = 1'b0;

        // Stray response in IDLE is sticky until reset.
        do_reset();
        bus.cache_resp_valid = 1'b1;
        @(negedge clk);
        chk("t5_no_strobe", 64'(bus.cli_resp_valid), 64'd0);
        tick();
        bus.cache_resp_valid = 1'b0;
        @(negedge clk);
        chk("t5_err_set", 64'(err), 64'd1);
        tick();
        bus.cli_req_valid = 4'b0001;
        complete(32'h0);
        @(negedge clk);
        chk("t5_err_sticky", 64'(err), 64'd1);
        do_reset();
        @(negedge clk);
        chk("t5_err_clear", 64'(err), 64'd0);

        // Reset in WAIT_RESP, then a late response.
        tick();
        bus.cli_req_valid = 4'b0001;
        tick();
        bus.cli_req_valid = '0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy_wait", 64'(busy), 64'd1);
        tick();
        rst = 1'b0;
        bus.cache_resp_valid = 1'b1;
        bus.cache_resp_rdata = 32'h1234;
        @(negedge clk);
        chk("t6_no_strobe", 64'(bus.cli_resp_valid), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        tick();
        bus.cache_resp_valid = 1'b0;
        bus.cli_req_valid    = 4'b1111;
        @(negedge clk);
        chk("t6_err", 64'(err), 64'd1);
        chk("t6_ptr0", 64'(bus.cli_req_ready), 64'h1);
        complete(32'h0);
        @(negedge clk);

        summary();
        $finish;
    end
endmodule
